// File: rtl/uart_pkg.sv
// uart_pkg: receiver states, APB register map and STATUS/CTRL layout
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} rx_state_t;

    localparam logic [3:0] ADDR_DATA   = 4'h0;
    localparam logic [3:0] ADDR_STATUS = 4'h4;
    localparam logic [3:0] ADDR_CTRL   = 4'h8;

    localparam int ST_EMPTY   = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_OVERRUN = 2;
    localparam int ST_PARITY  = 3;
    localparam int ST_FRAME   = 4;
    localparam int ST_COUNT   = 8;

    localparam logic [1:0] CTRL_RST = 2'b01;

endpackage

// File: rtl/uart_rx_sync_fifo.sv
// uart_rx_sync_fifo: single-clock FIFO where a pop frees its slot before a same-cycle push
module uart_rx_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic                       dropped,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp;
    logic [AW-1:0]    rp;
    logic             do_pop;
    logic             do_push;

    assign empty   = count == '0;
    assign full    = count == CW'(DEPTH);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dropped = push & ~do_push;
    assign dout    = mem[rp];

    // pointers wrap modulo DEPTH; occupancy tracks accepted pushes and pops
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            wp    <= wp + AW'(do_push);
            rp    <= rp + AW'(do_pop);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // storage write for accepted pushes
    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= din;
    end

endmodule

// File: rtl/uart_rx_apb_fifo.sv
// uart_rx_apb_fifo: oversampling UART receiver with RX FIFO and APB register interface
module uart_rx_apb_fifo
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 8,
    parameter bit PARITY_EN  = 1'b0,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        tick,
    input  logic        Rx,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [3:0]  PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic        RX_Done,
    output logic        irq
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    rx_state_t            state;
    rx_state_t            state_n;
    logic                 rx_m;
    logic                 rx_s;
    logic [TW-1:0]        tcnt;
    logic [TW-1:0]        tcnt_n;
    logic [BW-1:0]        bcnt;
    logic [BW-1:0]        bcnt_n;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] shreg_n;
    logic                 perr;
    logic                 perr_n;
    logic                 half;
    logic                 mid;
    logic                 push;
    logic                 set_pe;
    logic                 set_fe;
    logic                 enable;
    logic                 irq_en;
    logic                 overrun;
    logic                 parity_err;
    logic                 frame_err;
    logic                 access;
    logic                 rd_data;
    logic                 wr_status;
    logic                 wr_ctrl;
    logic                 pop;
    logic                 full;
    logic                 empty;
    logic                 dropped;
    logic [CW-1:0]        count;
    logic [DATA_BITS-1:0] head;
    logic [15:0]          status;
    logic                 unused_pwdata;

    assign PREADY        = 1'b1;
    assign PSLVERR       = 1'b0;
    assign unused_pwdata = ^PWDATA[31:5];

    // two-flop synchronizer on the asynchronous line, idling high
    always_ff @(posedge PCLK) begin
        if (!PRESETn) {rx_s, rx_m} <= 2'b11;
        else          {rx_s, rx_m} <= {rx_m, Rx};
    end

    assign half = tick && tcnt == TW'(OVERSAMPLE / 2 - 1);
    assign mid  = tick && tcnt == TW'(OVERSAMPLE - 1);

    // next-state, bit timing and end-of-frame strobes; disable aborts any frame
    always_comb begin
        state_n = state;
        tcnt_n  = tick ? tcnt + 1'b1 : tcnt;
        bcnt_n  = bcnt;
        shreg_n = shreg;
        perr_n  = perr;
        push    = 1'b0;
        set_pe  = 1'b0;
        set_fe  = 1'b0;
        if (!enable) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: if (tick && !rx_s) begin
                    state_n = START;
                    tcnt_n  = '0;
                end
                START: if (half) begin
                    state_n = rx_s ? IDLE : DATA;
                    tcnt_n  = '0;
                    bcnt_n  = '0;
                    perr_n  = 1'b0;
                end
                DATA: if (mid) begin
                    shreg_n = {rx_s, shreg[DATA_BITS-1:1]};
                    tcnt_n  = '0;
                    bcnt_n  = bcnt + 1'b1;
                    if (bcnt == BW'(DATA_BITS - 1)) state_n = PARITY_EN ? PARITY : STOP;
                end
                PARITY: if (mid) begin
                    perr_n  = rx_s != (^shreg ^ PARITY_ODD);
                    tcnt_n  = '0;
                    state_n = STOP;
                end
                STOP: if (mid) begin
                    state_n = rx_s ? IDLE : BREAK;
                    push    = rx_s & ~perr & PRESETn;
                    set_pe  = rx_s & perr;
                    set_fe  = ~rx_s;
                end
                BREAK: if (tick && rx_s) state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    // receiver state and datapath registers; reset drops any partial frame
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state <= IDLE;
            tcnt  <= '0;
            bcnt  <= '0;
            shreg <= '0;
            perr  <= 1'b0;
        end else begin
            state <= state_n;
            tcnt  <= tcnt_n;
            bcnt  <= bcnt_n;
            shreg <= shreg_n;
            perr  <= perr_n;
        end
    end

    assign RX_Done = push;

    uart_rx_sync_fifo #(
        .WIDTH(DATA_BITS),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (PCLK),
        .rst_n  (PRESETn),
        .push   (push),
        .din    (shreg),
        .pop    (pop),
        .dout   (head),
        .full   (full),
        .empty  (empty),
        .dropped(dropped),
        .count  (count)
    );

    assign access    = PSEL & PENABLE;
    assign rd_data   = access & ~PWRITE & (PADDR == ADDR_DATA);
    assign wr_status = access & PWRITE & (PADDR == ADDR_STATUS);
    assign wr_ctrl   = access & PWRITE & (PADDR == ADDR_CTRL);
    assign pop       = rd_data & ~empty;

    // STATUS word assembly
    always_comb begin
        status                  = '0;
        status[ST_EMPTY]        = empty;
        status[ST_FULL]         = full;
        status[ST_OVERRUN]      = overrun;
        status[ST_PARITY]       = parity_err;
        status[ST_FRAME]        = frame_err;
        status[ST_COUNT +: 8]   = 8'(count);
    end

    // read mux, combinational from PADDR; empty DATA reads return zero
    always_comb begin
        PRDATA = PADDR == ADDR_DATA   ? (empty ? '0 : 32'(head)) :
                 PADDR == ADDR_STATUS ? 32'(status) :
                 PADDR == ADDR_CTRL   ? {30'd0, irq_en, enable} : '0;
    end

    // sticky errors (set beats write-1-to-clear), control register, registered irq
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            overrun           <= 1'b0;
            parity_err        <= 1'b0;
            frame_err         <= 1'b0;
            {irq_en, enable}  <= CTRL_RST;
            irq               <= 1'b0;
        end else begin
            overrun    <= dropped | (overrun & ~(wr_status & PWDATA[ST_OVERRUN]));
            parity_err <= set_pe | (parity_err & ~(wr_status & PWDATA[ST_PARITY]));
            frame_err  <= set_fe | (frame_err & ~(wr_status & PWDATA[ST_FRAME]));
            if (wr_ctrl) {irq_en, enable} <= PWDATA[1:0];
            irq        <= irq_en & (~empty | overrun | parity_err | frame_err);
        end
    end

endmodule

// File: tb/tb_uart_rx_apb_fifo.sv
// tb_uart_rx_apb_fifo: directed checks of frame reception, FIFO, errors and APB access
module tb_uart_rx_apb_fifo;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        tick;
    logic        PENABLE;
    logic        PWRITE;
    logic [3:0]  PADDR;
    logic [31:0] PWDATA;
    logic        rx0, rx1, psel0, psel1;
    logic [31:0] prdata0, prdata1;
    logic        pready0, pready1, pslverr0, pslverr1;
    logic        done0, done1, irq0, irq1;
    int          checks = 0;
    int          errors = 0;
    int          n_done0 = 0;
    int          n_done1 = 0;

    always #5 PCLK = ~PCLK;

    uart_rx_apb_fifo dut0 (
        .PCLK(PCLK), .PRESETn(PRESETn), .tick(tick), .Rx(rx0),
        .PSEL(psel0), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(prdata0), .PREADY(pready0), .PSLVERR(pslverr0), .RX_Done(done0), .irq(irq0)
    );

    uart_rx_apb_fifo #(.PARITY_EN(1'b1)) dut1 (
        .PCLK(PCLK), .PRESETn(PRESETn), .tick(tick), .Rx(rx1),
        .PSEL(psel1), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(prdata1), .PREADY(pready1), .PSLVERR(pslverr1), .RX_Done(done1), .irq(irq1)
    );

    always @(negedge PCLK) begin
        if (done0) n_done0++;
        if (done1) n_done1++;
    end

    task automatic apb_read(input int d, input logic [3:0] a, output logic [31:0] v);
        @(negedge PCLK);
        psel0 = (d == 0); psel1 = (d == 1); PADDR = a; PWRITE = 1'b0; PENABLE = 1'b0;
        @(negedge PCLK);
        PENABLE = 1'b1;
        #1 v = d ? prdata1 : prdata0;
        @(negedge PCLK);
        psel0 = 1'b0; psel1 = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic apb_write(input int d, input logic [3:0] a, input logic [31:0] w);
        @(negedge PCLK);
        psel0 = (d == 0); psel1 = (d == 1); PADDR = a; PWRITE = 1'b1; PWDATA = w; PENABLE = 1'b0;
        @(negedge PCLK);
        PENABLE = 1'b1;
        @(negedge PCLK);
        psel0 = 1'b0; psel1 = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic drive_bit(input int d, input logic b);
        if (d == 1) rx1 = b; else rx0 = b;
        repeat (16) @(negedge PCLK);
    endtask

    task automatic send_frame(input int d, input logic [7:0] data, input logic par, input logic stop);
        drive_bit(d, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d, data[i]);
        if (d == 1) drive_bit(d, par);
        drive_bit(d, stop);
        if (stop) repeat (4) @(negedge PCLK);
    endtask

    task automatic test_reset;
        logic [31:0] v;
        PRESETn = 1'b0;
        repeat (3) @(negedge PCLK);
        checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done0); end
        checks++; if (irq0 !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", irq0); end
        PRESETn = 1'b1;
        @(negedge PCLK);
        apb_read(0, 4'h4, v);
        checks++; if (v !== 32'h1) begin errors++; $display("FAIL reset_status: got %h want %h", v, 32'h1); end
        apb_read(0, 4'h8, v);
        checks++; if (v !== 32'h1) begin errors++; $display("FAIL reset_ctrl: got %h want %h", v, 32'h1); end
        apb_read(1, 4'h4, v);
        checks++; if (v !== 32'h1) begin errors++; $display("FAIL reset_status1: got %h want %h", v, 32'h1); end
        apb_read(0, 4'hC, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL unmapped_read: got %h want 0", v); end
        checks++; if ({pready0, pslverr0, pready1, pslverr1} !== 4'b1010) begin errors++; $display("FAIL ready_slverr: got %b want 1010", {pready0, pslverr0, pready1, pslverr1}); end
    endtask

    task automatic test_frame;
        logic [31:0] v;
        int b;
        b = n_done0;
        send_frame(0, 8'hA5, 1'b0, 1'b1);
        checks++; if (n_done0 - b !== 1) begin errors++; $display("FAIL frame_done: got %0d want 1", n_done0 - b); end
        apb_read(0, 4'h4, v);
        checks++; if (v !== 32'h0100) begin errors++; $display("FAIL frame_status: got %h want %h", v, 32'h0100); end
        apb_write(0, 4'h0, 32'hFF);
        apb_read(0, 4'h0, v);
        checks++; if (v !== 32'hA5) begin errors++; $display("FAIL frame_data: got %h want %h", v, 32'hA5); end
        apb_read(0, 4'h4, v);
        checks++; if (v !== 32'h1) begin errors++; $display("FAIL frame_empty: got %h want %h", v, 32'h1); end
        apb_read(0, 4'h0, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL empty_read: got %h want 0", v); end
    endtask

    task automatic test_glitch;
        logic [31:0] v;
        int b;
        b = n_done0;
        rx0 = 1'b0;
        repeat (6) @(negedge PCLK);
        rx0 = 1'b1;
        repeat (40) @(negedge PCLK);
        checks++; if (n_done0 !== b) begin errors++; $display("FAIL glitch_done: got %0d want %0d", n_done0, b); end
        apb_read(0, 4'h4, v);
        checks++; if (v !== 32'h1) begin errors++; $display("FAIL glitch_status: got %h want %h", v, 32'h1); end
        send_frame(0, 8'h3C, 1'b0, 1'b1);
        apb_read(0, 4'h0, v);
        checks++; if (v !== 32'h3C) begin errors++; $display("FAIL glitch_next: got %h want %h", v, 32'h3C); end
    endtask

    task automatic test_overrun;
        logic [31:0] v;
        int b;
        b = n_done0;
        for (int i = 1; i <= 9; i++) send_frame(0, 8'(8'h10 + i), 1'b0, 1'b1);
        checks++; if (n_done0 - b !== 9) begin errors++; $display("FAIL ovr_done: got %0d want 9", n_done0 - b); end
        apb_read(0, 4'h4, v);
        checks++; if (v !== 32'h0806) begin errors++; $display("FAIL ovr_status: got %h want %h", v, 32'h0806); end
        for (int i = 1; i <= 8; i++) begin
            apb_read(0, 4'h0, v);
            checks++; if (v !== 32'(8'h10 + i)) begin errors++; $display("FAIL ovr_order%0d: got %h want %h", i, v, 32'(8'h10 + i)); end
        end
        apb_read(0, 4'h4, v);
        checks++; if (v !== 32'h0005) begin errors++; $display("FAIL ovr_drained: got %h want %h", v, 32'h0005); end
        apb_write(0, 4'h4, 32'h04);
        apb_read(0, 4'h4, v);
        checks++; if (v !== 32'h1) begin errors++; $display("FAIL ovr_clear: got %h want %h", v, 32'h1); end
    endtask

    task automatic test_ctrl;
        logic [31:0] v;
        int b;
        apb_write(0, 4'h8, 32'h3);
        send_frame(0, 8'h81, 1'b0, 1'b1);
        repeat (2) @(negedge PCLK);
        checks++; if (irq0 !== 1'b1) begin errors++; $display("FAIL irq_set: got %b want 1", irq0); end
        apb_read(0, 4'h0, v);
        checks++; if (v !== 32'h81) begin errors++; $display("FAIL irq_data: got %h want %h", v, 32'h81); end
        repeat (2) @(negedge PCLK);
        checks++; if (irq0 !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b want 0", irq0); end
        apb_write(0, 4'h8, 32'h0);
        b = n_done0;
        send_frame(0, 8'h42, 1'b0, 1'b1);
        checks++; if (n_done0 !== b) begin errors++; $display("FAIL disabled_done: got %0d want %0d", n_done0, b); end
        apb_read(0, 4'h4, v);
        checks++; if (v !== 32'h1) begin errors++; $display("FAIL disabled_status: got %h want %h", v, 32'h1); end
        apb_read(0, 4'h8, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL ctrl_readback: got %h want 0", v); end
        apb_write(0, 4'h8, 32'h1);
    endtask

    task automatic test_parity;
        logic [31:0] v;
        int b;
        b = n_done1;
        send_frame(1, 8'h03, 1'b1, 1'b1);
        checks++; if (n_done1 !== b) begin errors++; $display("FAIL parity_bad_done: got %0d want %0d", n_done1, b); end
        apb_read(1, 4'h4, v);
        checks++; if (v !== 32'h0009) begin errors++; $display("FAIL parity_err: got %h want %h", v, 32'h0009); end
        send_frame(1, 8'h03, 1'b0, 1'b1);
        checks++; if (n_done1 - b !== 1) begin errors++; $display("FAIL parity_good_done: got %0d want 1", n_done1 - b); end
        apb_read(1, 4'h4, v);
        checks++; if (v !== 32'h0108) begin errors++; $display("FAIL parity_good_status: got %h want %h", v, 32'h0108); end
        apb_read(1, 4'h0, v);
        checks++; if (v !== 32'h03) begin errors++; $display("FAIL parity_data: got %h want %h", v, 32'h03); end
        apb_write(1, 4'h4, 32'h08);
        apb_read(1, 4'h4, v);
        checks++; if (v !== 32'h1) begin errors++; $display("FAIL parity_clear: got %h want %h", v, 32'h1); end
    endtask

    task automatic test_break;
        logic [31:0] v;
        int b;
        b = n_done0;
        send_frame(0, 8'h55, 1'b0, 1'b0);
        repeat (48) @(negedge PCLK);
        apb_read(0, 4'h4, v);
        checks++; if (v !== 32'h0011) begin errors++; $display("FAIL break_low: got %h want %h", v, 32'h0011); end
        rx0 = 1'b1;
        repeat (20) @(negedge PCLK);
        checks++; if (n_done0 !== b) begin errors++; $display("FAIL break_done: got %0d want %0d", n_done0, b); end
        apb_read(0, 4'h4, v);
        checks++; if (v !== 32'h0011) begin errors++; $display("FAIL break_nostart: got %h want %h", v, 32'h0011); end
        apb_write(0, 4'h4, 32'h10);
        send_frame(0, 8'h3C, 1'b0, 1'b1);
        apb_read(0, 4'h0, v);
        checks++; if (v !== 32'h3C) begin errors++; $display("FAIL break_next: got %h want %h", v, 32'h3C); end
        apb_read(0, 4'h4, v);
        checks++; if (v !== 32'h1) begin errors++; $display("FAIL break_final: got %h want %h", v, 32'h1); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] v;
        logic [7:0]  d;
        int b;
        d = 8'h5A;
        send_frame(0, 8'h77, 1'b0, 1'b1);
        b = n_done0;
        drive_bit(0, 1'b0);
        for (int i = 0; i < 3; i++) drive_bit(0, d[i]);
        PRESETn = 1'b0;
        rx0 = 1'b1;
        repeat (3) @(negedge PCLK);
        PRESETn = 1'b1;
        repeat (20) @(negedge PCLK);
        checks++; if (n_done0 !== b) begin errors++; $display("FAIL rstmid_done: got %0d want %0d", n_done0, b); end
        apb_read(0, 4'h4, v);
        checks++; if (v !== 32'h1) begin errors++; $display("FAIL rstmid_status: got %h want %h", v, 32'h1); end
        send_frame(0, d, 1'b0, 1'b1);
        checks++; if (n_done0 - b !== 1) begin errors++; $display("FAIL rstmid_next_done: got %0d want 1", n_done0 - b); end
        apb_read(0, 4'h0, v);
        checks++; if (v !== 32'h5A) begin errors++; $display("FAIL rstmid_next_data: got %h want %h", v, 32'h5A); end
    endtask

    initial begin
        PRESETn = 1'b0; tick = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 4'h0; PWDATA = 32'h0;
        rx0 = 1'b1; rx1 = 1'b1; psel0 = 1'b0; psel1 = 1'b0;
        @(negedge PCLK);
        test_reset;
        test_frame;
        test_glitch;
        test_overrun;
        test_ctrl;
        test_parity;
        test_break;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
